// File: rtl/ps2_host_tx_if.sv
// Byte handshake between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_error,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_error,
    output busy
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device clock edges and checks the device ACK.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | both lines released, ready for a byte
// INHIBIT     | hold PS2_CLK low for INHIBIT_CYCLES
// REQ         | start bit: PS2_DATA and PS2_CLK both pulled low for one cycle
// SEND        | clock released; drive d0..d7, parity, stop on device falls
// ACK         | sample device ACK on the 11th falling edge
// WAIT_IDLE   | wait for the device to release both lines, then report done
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  ps2_host_tx_if.slave  bus,
  input  logic          i_ps2_clk,
  input  logic          i_ps2_data,
  output logic          o_ps2_clk_low,
  output logic          o_ps2_data_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_clk_m, r_clk_s, r_clk_d;
  logic             r_data_m, r_data_s;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             r_parity, w_parity_nxt;
  logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [INH_W-1:0] r_inh, w_inh_nxt;
  logic [WD_W-1:0]  r_wd, w_wd_nxt;
  logic             r_clk_low, w_clk_low_nxt;
  logic             r_data_low, w_data_low_nxt;
  logic             r_done, w_done_nxt;
  logic             r_error, w_error_nxt;
  logic             r_busy, r_ready;
  logic             w_fall;
  logic             w_bit;

  assign w_fall = r_clk_d & ~r_clk_s;

  // Two-flop synchronizers for both raw lines plus the clock edge-detect flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_m  <= 1'b1;
      r_clk_s  <= 1'b1;
      r_clk_d  <= 1'b1;
      r_data_m <= 1'b1;
      r_data_s <= 1'b1;
    end else begin
      r_clk_m  <= i_ps2_clk;
      r_clk_s  <= r_clk_m;
      r_clk_d  <= r_clk_s;
      r_data_m <= i_ps2_data;
      r_data_s <= r_data_m;
    end
  end

  // Frame bit selected by the bit counter: data LSB first, parity, then stop.
  always_comb begin
    w_bit = 1'b1;
    if (r_bit_cnt < 4'd8) begin
      w_bit = r_byte[r_bit_cnt[2:0]];
    end else if (r_bit_cnt == 4'd8) begin
      w_bit = r_parity;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_nxt     = r_byte;
    w_parity_nxt   = r_parity;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_inh_nxt      = r_inh;
    w_wd_nxt       = (r_wd == '0) ? r_wd : r_wd - 1'b1;
    w_clk_low_nxt  = r_clk_low;
    w_data_low_nxt = r_data_low;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_low_nxt  = 1'b0;
        w_data_low_nxt = 1'b0;
        if (bus.tx_valid && r_ready) begin
          w_byte_nxt    = bus.tx_data;
          w_parity_nxt  = ~^bus.tx_data;
          w_bit_cnt_nxt = 4'd0;
          w_inh_nxt     = INH_LOAD;
          w_clk_low_nxt = 1'b1;
          w_state_nxt   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_inh == '0) begin
          w_data_low_nxt = 1'b1;
          w_state_nxt    = S_REQ;
        end else begin
          w_inh_nxt = r_inh - 1'b1;
        end
      end
      S_REQ: begin
        if (r_wd == '0) begin
          w_state_nxt    = S_IDLE;
          w_clk_low_nxt  = 1'b0;
          w_data_low_nxt = 1'b0;
          w_error_nxt    = 1'b1;
        end else begin
          w_clk_low_nxt = 1'b0;
          w_state_nxt   = S_SEND;
        end
      end
      S_SEND: begin
        if (r_wd == '0) begin
          w_state_nxt    = S_IDLE;
          w_clk_low_nxt  = 1'b0;
          w_data_low_nxt = 1'b0;
          w_error_nxt    = 1'b1;
        end else if (w_fall) begin
          w_wd_nxt       = WD_LOAD;
          w_data_low_nxt = ~w_bit;
          if (r_bit_cnt == 4'd9) begin
            w_state_nxt = S_ACK;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (r_wd == '0) begin
          w_state_nxt    = S_IDLE;
          w_clk_low_nxt  = 1'b0;
          w_data_low_nxt = 1'b0;
          w_error_nxt    = 1'b1;
        end else if (w_fall) begin
          w_wd_nxt = WD_LOAD;
          if (!r_data_s) begin
            w_state_nxt = S_WAIT_IDLE;
          end else begin
            w_state_nxt    = S_IDLE;
            w_data_low_nxt = 1'b0;
            w_error_nxt    = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (r_wd == '0) begin
          w_state_nxt    = S_IDLE;
          w_clk_low_nxt  = 1'b0;
          w_data_low_nxt = 1'b0;
          w_error_nxt    = 1'b1;
        end else if (r_clk_s && r_data_s) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_fall) begin
          w_wd_nxt = WD_LOAD;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_clk_low_nxt  = 1'b0;
        w_data_low_nxt = 1'b0;
      end
    endcase

    // Every state entry restarts the watchdog.
    if (w_state_nxt != r_state) begin
      w_wd_nxt = WD_LOAD;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_byte     <= 8'h00;
      r_parity   <= 1'b0;
      r_bit_cnt  <= 4'd0;
      r_inh      <= '0;
      r_wd       <= '0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte     <= w_byte_nxt;
      r_parity   <= w_parity_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_inh      <= w_inh_nxt;
      r_wd       <= w_wd_nxt;
      r_clk_low  <= w_clk_low_nxt;
      r_data_low <= w_data_low_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_ready    <= (w_state_nxt == S_IDLE);
    end
  end

  assign o_ps2_clk_low  = r_clk_low;
  assign o_ps2_data_low = r_data_low;
  assign bus.tx_ready   = r_ready;
  assign bus.tx_done    = r_done;
  assign bus.tx_error   = r_error;
  assign bus.busy       = r_busy;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 INHIBIT_CYCLES, 10000, clk cycles PS2_CLK is held low before the start bit (100 us at 100 MHz).
REQ-002 TIMEOUT_CYCLES, 200000, max clk cycles without a device event before abort (2 ms at 100 MHz).
REQ-003 clk  input  1  system clock; all logic SHALL use its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 tx_data  input  8  command byte to keyboard (e.g. 0xED set-LEDs).
REQ-006 tx_valid  input  1  send request; byte SHALL be accepted on a cycle with tx_valid=1 and tx_ready=1.
REQ-007 tx_ready  output  1  SHALL be 1 only in IDLE and not in reset.
REQ-008 PS2_CLK  input  1  raw keyboard clock line, asynchronous.
REQ-009 PS2_DATA  input  1  raw keyboard data line, asynchronous.
REQ-010 ps2_clk_low  output  1  1 = pull PS2_CLK low (open collector), 0 = release.
REQ-011 ps2_data_low  output  1  1 = pull PS2_DATA low, 0 = release.
REQ-012 tx_done  output  1  one-cycle pulse: frame sent and device ACK received.
REQ-013 tx_error  output  1  one-cycle pulse: missing ACK or timeout.
REQ-014 busy  output  1  SHALL be 1 in every state except IDLE.

Function
REQ-015 PS2_CLK and PS2_DATA SHALL each pass a 2-flop synchronizer; falling edge = previous synced 1 and current synced 0; protocol decisions SHALL use only synced values.
REQ-016 FSM states SHALL be IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: both lines released. On accept: latch tx_data, latch odd parity (~^tx_data), clear bit counter, go INHIBIT.
REQ-018 INHIBIT: ps2_clk_low=1, ps2_data_low=0 for exactly INHIBIT_CYCLES cycles, then go REQ.
REQ-019 REQ: ps2_clk_low=1 and ps2_data_low=1 (start bit) for exactly 1 cycle, then go SEND with ps2_clk_low=0 and ps2_data_low held 1.
REQ-020 SEND: on each synced falling edge, drive the next frame bit with ps2_data_low = ~bit, order d0..d7, parity, stop (release); after the 10th falling edge go ACK.
REQ-021 Bit counter SHALL be 4 bits, count 0..9, never wrap within a frame.
REQ-022 ACK: on next synced falling edge sample synced PS2_DATA; 0 -> WAIT_IDLE; 1 -> tx_error pulse, go IDLE.
REQ-023 WAIT_IDLE: when synced PS2_CLK=1 and PS2_DATA=1, pulse tx_done and go IDLE.
REQ-024 Watchdog SHALL clear on every state entry and every synced falling edge in SEND/ACK and in WAIT_IDLE; reaching TIMEOUT_CYCLES in REQ..WAIT_IDLE SHALL release both lines, pulse tx_error, go IDLE.
REQ-025 Every accepted byte SHALL produce exactly one tx_done or one tx_error pulse, never both.
REQ-026 tx_valid SHALL be ignored while busy; tx_data changes after accept SHALL have no effect.
REQ-027 All outputs registered; latency from PS2_CLK pin falling edge to ps2_data_low update SHALL be at most 3 clk cycles.
REQ-028 INHIBIT and watchdog counter widths SHALL hold their parameter values without overflow.

Reset
REQ-029 While rst=1 at a clock edge: state IDLE, ps2_clk_low=0, ps2_data_low=0, tx_done=0, tx_error=0, busy=0, tx_ready=0; synchronizer flops set to 1; tx_ready=1 on first cycle after rst falls.
REQ-030 rst mid-frame SHALL release both lines at that edge and emit neither tx_done nor tx_error.

Verification
REQ-031 tx_data=0xED, device model clocks 11 falling edges at ~12 kHz and ACKs -> sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse, tx_error stays 0.
REQ-032 Parity sweep 0x00 -> parity 1, 0x01 -> 0, 0xFF -> 1, 0x80 -> 0; each ends in tx_done.
REQ-033 Device leaves PS2_DATA high on 11th edge -> one tx_error pulse, both lines released, tx_ready=1 next cycle.
REQ-034 Device never clocks after REQ -> tx_error exactly TIMEOUT_CYCLES cycles after SEND entry (+/-1), lines released.
REQ-035 Inhibit check: ps2_clk_low high for INHIBIT_CYCLES+1 consecutive cycles; ps2_data_low rises only in the last of them; tx_valid pulsed during frame is ignored.
REQ-036 rst asserted after 4th data bit -> both lines released next edge, no done/error; following tx_valid with 0x55 completes with tx_done.
